// File: rtl/regfile_nr_mw_if.sv
// Register-file access bundle: write/alloc/clear from the issue side, gated reads and conflict flag back.
// The master drives requests; the slave (the register file) returns combinational read results.
interface regfile_nr_mw_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int NUM_WR     = 2,
    parameter int NUM_RD     = 3
);
    localparam int AW = $clog2(DEPTH);

    logic                           clear_i;
    logic [NUM_WR-1:0]              write_en_i;
    logic [NUM_WR*AW-1:0]           write_addr_i;
    logic [NUM_WR*DATA_WIDTH-1:0]   write_data_i;
    logic                           alloc_en_i;
    logic [AW-1:0]                  alloc_addr_i;
    logic [NUM_RD-1:0]              read_en_i;
    logic [NUM_RD*AW-1:0]           read_addr_i;
    logic [NUM_RD*DATA_WIDTH-1:0]   read_data_o;
    logic [NUM_RD-1:0]              read_ready_o;
    logic                           write_conflict_o;

    modport master (
        output clear_i, write_en_i, write_addr_i, write_data_i,
               alloc_en_i, alloc_addr_i, read_en_i, read_addr_i,
        input  read_data_o, read_ready_o, write_conflict_o
    );

    modport slave (
        input  clear_i, write_en_i, write_addr_i, write_data_i,
               alloc_en_i, alloc_addr_i, read_en_i, read_addr_i,
        output read_data_o, read_ready_o, write_conflict_o
    );
endinterface

// File: rtl/regfile_nr_mw.sv
// Multi-port register file with pending scoreboard; writes land in 1 edge, reads are combinational
// (optional same-cycle write-through). No backpressure: every request is accepted every cycle.
module regfile_nr_mw #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int NUM_WR     = 2,
    parameter int NUM_RD     = 3,
    parameter bit BYPASS     = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    regfile_nr_mw_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][DATA_WIDTH-1:0]  mem_q, mem_d;
    logic [DEPTH-1:0]                  pend_q, pend_d;
    logic                              conflict_q, conflict_d;

    logic [NUM_WR-1:0][AW-1:0]         wr_addr;
    logic [NUM_WR-1:0][DATA_WIDTH-1:0] wr_dat;
    logic [NUM_RD-1:0][AW-1:0]         rd_addr;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_dat;
    logic [NUM_RD-1:0]                 rd_rdy;
    logic                              collide;

    assign wr_addr = bus.write_addr_i;
    assign wr_dat  = bus.write_data_i;
    assign rd_addr = bus.read_addr_i;

    function automatic logic in_range(input logic [AW-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    always_comb begin
        collide = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int k = i + 1; k < NUM_WR; k++) begin
                if (bus.write_en_i[i] && bus.write_en_i[k] && (wr_addr[i] == wr_addr[k])) begin
                    collide = 1'b1;
                end
            end
        end
    end

    always_comb begin
        mem_d      = mem_q;
        pend_d     = pend_q;
        conflict_d = 1'b0;
        if (bus.clear_i) begin
            mem_d  = '0;
            pend_d = '0;
        end else begin
            conflict_d = collide;
            // Walk from lowest priority up so the lowest-index port is applied last and wins.
            for (int k = NUM_WR - 1; k >= 0; k--) begin
                if (bus.write_en_i[k] && in_range(wr_addr[k])) begin
                    mem_d[wr_addr[k]]  = wr_dat[k];
                    pend_d[wr_addr[k]] = 1'b0;
                end
            end
            // A fresh allocation supersedes a write retiring the previous producer.
            if (bus.alloc_en_i && in_range(bus.alloc_addr_i)) begin
                pend_d[bus.alloc_addr_i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q      <= '0;
            pend_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            pend_q     <= pend_d;
            conflict_q <= conflict_d;
        end
    end

    always_comb begin
        logic hit;
        rd_dat = '0;
        rd_rdy = '0;
        hit    = 1'b0;
        for (int j = 0; j < NUM_RD; j++) begin
            hit = 1'b0;
            if (bus.read_en_i[j]) begin
                if (!in_range(rd_addr[j])) begin
                    rd_rdy[j] = 1'b1;
                end else begin
                    rd_dat[j] = mem_q[rd_addr[j]];
                    rd_rdy[j] = ~pend_q[rd_addr[j]];
                    if (BYPASS && !bus.clear_i) begin
                        for (int k = NUM_WR - 1; k >= 0; k--) begin
                            if (bus.write_en_i[k] && (wr_addr[k] == rd_addr[j])) begin
                                rd_dat[j] = wr_dat[k];
                                hit       = 1'b1;
                            end
                        end
                        if (hit) begin
                            rd_rdy[j] = ~(bus.alloc_en_i && (bus.alloc_addr_i == rd_addr[j]));
                        end
                    end
                end
            end
        end
    end

    assign bus.read_data_o      = rd_dat;
    assign bus.read_ready_o     = rd_rdy;
    assign bus.write_conflict_o = conflict_q;
endmodule
